// File: rtl/demux14_stream.sv
// Registered 1:4 stream demultiplexer: one input handshake steered into four
// single-entry lane buffers, by explicit select or by a round-robin pointer.
module demux14_stream #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         sel,
   input  logic               auto,
   output logic               in_ready,
   output logic [3:0]         out_valid,
   output logic [4*WIDTH-1:0] out_data,
   input  logic [3:0]         out_ready,
   output logic [1:0]         ptr
);

   logic [3:0]       vld_p1;
   logic [WIDTH-1:0] data_p1 [4];
   logic [1:0]       ptr_p1;

   logic [1:0] tgt;
   logic       accept;
   logic [3:0] drain;

   // A full target lane still accepts when its consumer drains it this cycle.
   assign tgt      = auto ? ptr_p1 : sel;
   assign in_ready = ~vld_p1[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;
   assign drain    = vld_p1 & out_ready;

   // ---- lane buffer stage ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 4'b0000;
         ptr_p1 <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            data_p1[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && (tgt == 2'(i))) begin
               vld_p1[i]  <= 1'b1;
               data_p1[i] <= in_data;
            end else if (drain[i]) begin
               vld_p1[i]  <= 1'b0;
            end
         end
         if (accept && auto) begin
            ptr_p1 <= ptr_p1 + 2'd1;
         end
      end
   end

   // Data registers are kept after a drain, so out_data holds the last item.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < 4; i++) begin
         out_data[i*WIDTH +: WIDTH] = data_p1[i];
      end
   end

   assign out_valid = vld_p1;
   assign ptr       = ptr_p1;

endmodule
